mem_arbiter: RTL and testbench

//  Miss handler between the CPU's I-cache/D-cache and the single unified main-memory port.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Miss handler serializing I/D line fills and dirty write-backs
// onto one main-memory port; drives the global pipeline ready.
module mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int LINE_WORDS = 4,
   parameter int LINE_W     = 16 * LINE_WORDS,
   parameter int MM_ADDR_W  = ADDR_W - $clog2(LINE_WORDS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_miss,
   input  logic [ADDR_W-1:0]    i_addr,
   input  logic                 d_miss,
   input  logic                 d_dirty,
   input  logic [ADDR_W-1:0]    d_addr,
   input  logic [ADDR_W-1:0]    d_evict_addr,
   input  logic [LINE_W-1:0]    d_evict_line,
   output logic [LINE_W-1:0]    fill_line,
   output logic                 i_fill_we,
   output logic                 d_fill_we,
   output logic                 mm_re,
   output logic                 mm_we,
   output logic [MM_ADDR_W-1:0] mm_addr,
   output logic [LINE_W-1:0]    mm_wdata,
   input  logic [LINE_W-1:0]    mm_rdata,
   input  logic                 mm_rdy,
   output logic                 ready
);

   localparam int OFF = $clog2(LINE_WORDS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_D_WB   = 3'd1;
   localparam logic [2:0] S_D_FILL = 3'd2;
   localparam logic [2:0] S_I_FILL = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]           r_state;
   logic [MM_ADDR_W-1:0] r_d_line;

   logic [MM_ADDR_W-1:0] w_i_line;
   logic [MM_ADDR_W-1:0] w_d_line;
   logic [MM_ADDR_W-1:0] w_ev_line;
   logic                 w_unused;

   assign w_i_line  = i_addr[ADDR_W-1:OFF];
   assign w_d_line  = d_addr[ADDR_W-1:OFF];
   assign w_ev_line = d_evict_addr[ADDR_W-1:OFF];
   assign w_unused  = ^{i_addr[OFF-1:0], d_addr[OFF-1:0],
                        d_evict_addr[OFF-1:0]};

   assign ready = (r_state == S_IDLE) & ~i_miss & ~d_miss & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_d_line  <= '0;
         fill_line <= '0;
         i_fill_we <= 1'b0;
         d_fill_we <= 1'b0;
         mm_re     <= 1'b0;
         mm_we     <= 1'b0;
         mm_addr   <= '0;
         mm_wdata  <= '0;
      end else begin
         i_fill_we <= 1'b0;
         d_fill_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // D first: it belongs to the older instruction
               if (d_miss && d_dirty) begin
                  r_state  <= S_D_WB;
                  mm_we    <= 1'b1;
                  mm_addr  <= w_ev_line;
                  mm_wdata <= d_evict_line;
                  r_d_line <= w_d_line;
               end else if (d_miss) begin
                  r_state  <= S_D_FILL;
                  mm_re    <= 1'b1;
                  mm_addr  <= w_d_line;
                  r_d_line <= w_d_line;
               end else if (i_miss) begin
                  r_state <= S_I_FILL;
                  mm_re   <= 1'b1;
                  mm_addr <= w_i_line;
               end
            end
            S_D_WB: begin
               if (mm_rdy) begin
                  r_state <= S_D_FILL;
                  mm_we   <= 1'b0;
                  mm_re   <= 1'b1;
                  mm_addr <= r_d_line;
               end
            end
            S_D_FILL, S_I_FILL: begin
               if (mm_rdy) begin
                  r_state   <= S_DONE;
                  mm_re     <= 1'b0;
                  fill_line <= mm_rdata;
                  d_fill_we <= (r_state == S_D_FILL);
                  i_fill_we <= (r_state == S_I_FILL);
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: begin
               r_state <= S_IDLE;
               mm_re   <= 1'b0;
               mm_we   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-programmable memory
// responder plus queue-based checking of requests and fills.
module tb_mem_arbiter;

   typedef struct {
      bit          we;
      logic [13:0] addr;
      logic [63:0] wdata;
   } req_t;

   typedef struct {
      bit          is_d;
      logic [63:0] data;
   } fill_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_miss, d_miss, d_dirty;
   logic [15:0] i_addr, d_addr, d_evict_addr;
   logic [63:0] d_evict_line;
   logic [63:0] fill_line;
   logic        i_fill_we, d_fill_we;
   logic        mm_re, mm_we;
   logic [13:0] mm_addr;
   logic [63:0] mm_wdata, mm_rdata;
   logic        mm_rdy;
   logic        ready;

   int errors = 0;
   int checks = 0;
   int both_hi = 0;
   int i_fills = 0;
   int d_fills = 0;

   req_t  req_q[$];
   fill_t fill_q[$];

   int          lat = 3;
   bit          spur = 1'b0;
   bit          use_fixed = 1'b0;
   logic [63:0] fixed_data = '0;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss(i_miss), .i_addr(i_addr),
      .d_miss(d_miss), .d_dirty(d_dirty), .d_addr(d_addr),
      .d_evict_addr(d_evict_addr), .d_evict_line(d_evict_line),
      .fill_line(fill_line), .i_fill_we(i_fill_we),
      .d_fill_we(d_fill_we), .mm_re(mm_re), .mm_we(mm_we),
      .mm_addr(mm_addr), .mm_wdata(mm_wdata),
      .mm_rdata(mm_rdata), .mm_rdy(mm_rdy), .ready(ready)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mem_val(input logic [13:0] a);
      return {a, 2'b00, a, 2'b01, a, 2'b10, a, 2'b11};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // memory model: completes each request lat cycles after it starts
   initial begin
      int cnt;
      bit rl;
      cnt = 0;
      rl = 1'b0;
      mm_rdy = 1'b0;
      mm_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mm_rdy = 1'b0;
         if (!rst_n) begin
            cnt = 0;
            rl = 1'b0;
         end else begin
            if (rl) begin
               cnt = 0;
               rl = 1'b0;
            end
            if (mm_re || mm_we) begin
               cnt++;
               if (cnt == lat) begin
                  mm_rdy = 1'b1;
                  mm_rdata = use_fixed ? fixed_data : mem_val(mm_addr);
                  rl = 1'b1;
               end
            end else if (spur) begin
               mm_rdy = 1'b1;
               mm_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
         end
      end
   end

   // monitor: pops the scoreboard on each request start and fill
   initial begin
      bit   p_re, p_we;
      req_t r;
      fill_t f;
      p_re = 1'b0;
      p_we = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mm_re && mm_we) both_hi++;
            if ((mm_we && !p_we) || (mm_re && !p_re)) begin
               if (req_q.size() == 0) begin
                  chk("req_unexpected", {50'd0, mm_addr}, 64'hFFFF);
               end else begin
                  r = req_q.pop_front();
                  chk("req_kind", {63'd0, mm_we}, {63'd0, r.we});
                  chk("req_addr", {50'd0, mm_addr}, {50'd0, r.addr});
                  if (r.we) chk("req_wdata", mm_wdata, r.wdata);
               end
            end
            if (i_fill_we) i_fills++;
            if (d_fill_we) d_fills++;
            if (i_fill_we || d_fill_we) begin
               if (fill_q.size() == 0) begin
                  chk("fill_unexpected", fill_line, ~fill_line);
               end else begin
                  f = fill_q.pop_front();
                  chk("fill_side", {62'd0, d_fill_we, i_fill_we},
                      {62'd0, f.is_d, !f.is_d});
                  chk("fill_data", fill_line, f.data);
               end
            end
         end
         p_re = mm_re;
         p_we = mm_we;
      end
   end

   task automatic run_miss(input bit is_d, input bit dirty,
                           input logic [15:0] a, input logic [15:0] ev_a,
                           input logic [63:0] ev_line);
      bit got;
      if (is_d && dirty)
         req_q.push_back('{1'b1, ev_a[15:2], ev_line});
      req_q.push_back('{1'b0, a[15:2], 64'd0});
      fill_q.push_back('{is_d,
         use_fixed ? fixed_data : mem_val(a[15:2])});
      @(posedge clk);
      #1;
      if (is_d) begin
         d_miss = 1'b1;
         d_dirty = dirty;
         d_addr = a;
         d_evict_addr = ev_a;
         d_evict_line = ev_line;
      end else begin
         i_miss = 1'b1;
         i_addr = a;
      end
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         got = is_d ? d_fill_we : i_fill_we;
      end
      chk("miss_timeout", {63'd0, got}, 64'd1);
      @(posedge clk);
      #1;
      d_miss = 1'b0;
      i_miss = 1'b0;
      d_addr = ~d_addr;
      i_addr = ~i_addr;
   endtask

   initial begin
      int  fi, fd;
      bit  rdy_hi, dseen, iseen, order_ok, fill_seen, stay_rdy;
      rst_n = 1'b0;
      i_miss = 1'b0;
      d_miss = 1'b0;
      d_dirty = 1'b0;
      i_addr = '0;
      d_addr = '0;
      d_evict_addr = '0;
      d_evict_line = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {63'd0, ready}, 64'd0);
      chk("rst_mm_re", {63'd0, mm_re}, 64'd0);
      chk("rst_fill_line", fill_line, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset in the middle of a D fill
      lat = 5;
      req_q.push_back('{1'b0, 14'h048D, 64'd0});
      d_miss = 1'b1;
      d_addr = 16'h1234;
      repeat (3) @(negedge clk);
      chk("pre_rst_mm_re", {63'd0, mm_re}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      d_miss = 1'b0;
      @(negedge clk);
      chk("midrst_mm_re", {63'd0, mm_re}, 64'd0);
      chk("midrst_dfill", {63'd0, d_fill_we}, 64'd0);
      chk("midrst_addr", {50'd0, mm_addr}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {63'd0, ready}, 64'd1);

      // clean I miss, exact timing
      lat = 3;
      use_fixed = 1'b1;
      fixed_data = {16{4'hA}};
      req_q.push_back('{1'b0, 14'h0048, 64'd0});
      fill_q.push_back('{1'b0, fixed_data});
      @(posedge clk);
      #1;
      i_miss = 1'b1;
      i_addr = 16'h0123;
      @(negedge clk);
      chk("t0_ready", {63'd0, ready}, 64'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("req_mm_re", {63'd0, mm_re}, 64'd1);
         chk("req_mm_addr", {50'd0, mm_addr}, 64'h48);
      end
      @(negedge clk);
      chk("t4_ifill", {63'd0, i_fill_we}, 64'd1);
      chk("t4_line", fill_line, {16{4'hA}});
      @(posedge clk);
      #1;
      i_miss = 1'b0;
      i_addr = 16'hFFFF;
      @(negedge clk);
      chk("t5_ready", {63'd0, ready}, 64'd1);
      chk("t5_line_hold", fill_line, {16{4'hA}});
      use_fixed = 1'b0;

      // dirty D miss: write-back then fill
      fi = i_fills;
      fd = d_fills;
      run_miss(1'b1, 1'b1, 16'h0800, 16'h0400, 64'hDEAD_BEEF_0BAD_F00D);
      chk("dirty_dfills", d_fills - fd, 64'd1);
      chk("dirty_ifills", i_fills - fi, 64'd0);

      // simultaneous clean misses: D first, ready low throughout
      lat = 2;
      req_q.push_back('{1'b0, 14'h0888, 64'd0});
      fill_q.push_back('{1'b1, mem_val(14'h0888)});
      req_q.push_back('{1'b0, 14'h0CCC, 64'd0});
      fill_q.push_back('{1'b0, mem_val(14'h0CCC)});
      @(posedge clk);
      #1;
      d_miss = 1'b1;
      d_dirty = 1'b0;
      d_addr = 16'h2222;
      i_miss = 1'b1;
      i_addr = 16'h3333;
      rdy_hi = 1'b0;
      dseen = 1'b0;
      iseen = 1'b0;
      order_ok = 1'b0;
      for (int k = 0; k < 80 && !iseen; k++) begin
         @(negedge clk);
         if (ready) rdy_hi = 1'b1;
         if (i_fill_we) begin
            iseen = 1'b1;
            order_ok = dseen;
            @(posedge clk);
            #1;
            i_miss = 1'b0;
         end
         if (d_fill_we) begin
            dseen = 1'b1;
            @(posedge clk);
            #1;
            d_miss = 1'b0;
         end
      end
      chk("both_done", {63'd0, iseen}, 64'd1);
      chk("both_order", {63'd0, order_ok}, 64'd1);
      chk("both_ready_low", {63'd0, rdy_hi}, 64'd0);
      @(negedge clk);
      chk("both_ready_end", {63'd0, ready}, 64'd1);

      // spurious mm_rdy while idle and in DONE
      spur = 1'b1;
      fi = i_fills;
      fd = d_fills;
      fill_seen = 1'b0;
      stay_rdy = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (i_fill_we || d_fill_we) fill_seen = 1'b1;
         if (!ready) stay_rdy = 1'b0;
      end
      chk("spur_no_fill", {63'd0, fill_seen}, 64'd0);
      chk("spur_ready", {63'd0, stay_rdy}, 64'd1);
      for (int n = 0; n < 8; n++) begin
         lat = 1 + (n % 4);
         run_miss(1'(n % 3 != 0), 1'(n % 2), 16'($urandom),
                  16'($urandom), {$urandom, $urandom});
      end
      chk("rand_fills", (i_fills - fi) + (d_fills - fd), 64'd8);
      spur = 1'b0;

      repeat (3) @(negedge clk);
      chk("never_both_hi", both_hi, 64'd0);
      chk("req_q_empty", req_q.size(), 64'd0);
      chk("fill_q_empty", fill_q.size(), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
